// File: rtl/jtframe_fir_mc.sv
// ---------------------------------------------------------------------------
// jtframe_fir_mc
// Multi-channel, run-time programmable FIR filter for the audio path. It sits
// between the sound mixer and the DAC / sigma-delta stage.
//
// Every channel keeps a circular history of the last KMAX samples. A sample
// strobe stores one new word per channel. It then starts a single
// time-multiplexed MAC pass over all channels, one product per clock,
// channel-major. Each channel result is shifted, saturated and presented on a
// registered bus together with a one-cycle valid pulse.
//
// Ports
//   rst        async active-high reset (history is re-cleared, coefs kept)
//   clk        clock
//   sample     one-cycle strobe, din valid, starts (or restarts) a pass
//   din        CH packed signed samples, channel 0 in the LSBs
//   dout       CH packed signed results, registered, same packing as din
//   out_valid  one-cycle pulse when dout updates
//   busy       high while clearing history or computing a pass
//   overrun    one-cycle pulse, a sample interrupted a pass in progress
//   cfg_we     coefficient write enable, honoured only while cfg_rdy=1
//   cfg_addr   tap index to write, values >= KMAX are dropped
//   cfg_data   coefficient value
//   cfg_rdy    ~busy
// ---------------------------------------------------------------------------
module jtframe_fir_mc #(
  parameter int WI     = 16,
  parameter int WC     = 16,
  parameter int CH     = 2,
  parameter int KMAX   = 64,
  parameter int AW     = 8,
  parameter int SHIFT  = WC - 2,
  parameter     COEFFS = ""
) (
  input  logic                 rst,
  input  logic                 clk,
  input  logic                 sample,
  input  logic [CH*WI-1:0]     din,
  output logic [CH*WI-1:0]     dout,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [WC-1:0]        cfg_data,
  output logic                 cfg_rdy
);

  // IW is the width that actually addresses KMAX entries. All internal
  // pointers use it, so the memories are exactly KMAX deep.
  localparam int IW = (KMAX > 1) ? $clog2(KMAX) : 1;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int WP = WI + WC;
  localparam int WA = WI + WC + AW;

  localparam logic signed [WA-1:0] MAXV = {{(WA-WI+1){1'b0}}, {(WI-1){1'b1}}};
  localparam logic signed [WA-1:0] MINV = {{(WA-WI+1){1'b1}}, {(WI-1){1'b0}}};

  typedef enum logic [2:0] {
    CLR, IDLE, MAC, DRAIN1, DRAIN2, OUT
  } state_t;

  state_t state, state_nxt;

  logic [IW-1:0] clr_cnt;
  logic [IW-1:0] wp;
  logic [IW-1:0] rd;
  logic [IW-1:0] k_cnt;
  logic [CW-1:0] ch_cnt;
  logic [IW-1:0] raddr;

  logic [CH*WI-1:0]    hist [KMAX];
  logic signed [WC-1:0] coef [KMAX];

  logic [CH*WI-1:0]     hist_q;
  logic signed [WC-1:0] coef_q;
  logic signed [WI-1:0] smp_sel;
  logic                 v1, v2;
  logic [CW-1:0]        ch1, ch2;
  logic signed [WP-1:0] prod;
  logic signed [WA-1:0] acc [CH];

  logic start;
  logic mac_last;
  logic clr_last;
  logic in_pass;

  // A sample is accepted in every state except CLR. In a pass state it
  // restarts the pass.
  assign start    = sample && (state != CLR);
  assign in_pass  = (state == MAC) || (state == DRAIN1) ||
                    (state == DRAIN2) || (state == OUT);
  assign mac_last = (state == MAC) && (ch_cnt == CW'(CH-1)) &&
                    (k_cnt == IW'(KMAX-1));
  assign clr_last = (clr_cnt == IW'(KMAX-1));

  assign busy    = (state != IDLE);
  assign cfg_rdy = ~busy;

  // Wrapped tap address (rd - k) mod KMAX. When rd < k, adding KMAX modulo
  // 2**IW gives the right entry. This still holds when KMAX == 2**IW, because
  // IW'(KMAX) is then 0.
  assign raddr = rd - k_cnt + ((rd < k_cnt) ? IW'(KMAX) : IW'(0));

  // Coefficients start at zero and are programmed through the config port.
  // Reset deliberately leaves them untouched.
  initial begin
    for (int k = 0; k < KMAX; k++) coef[k] = '0;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CLR;
    else     state <= state_nxt;
  end

  // Next-state logic. A sample during any pass state sends the FSM back to
  // MAC with a freshly cleared pipeline.
  always_comb begin
    state_nxt = state;
    case (state)
      CLR:     if (clr_last) state_nxt = IDLE;
      IDLE:    if (start)    state_nxt = MAC;
      MAC:     if (start)         state_nxt = MAC;
               else if (mac_last) state_nxt = DRAIN1;
      DRAIN1:  state_nxt = start ? MAC : DRAIN2;
      DRAIN2:  state_nxt = start ? MAC : OUT;
      OUT:     state_nxt = start ? MAC : IDLE;
      default: state_nxt = CLR;
    endcase
  end

  // History clear counter and the circular write / read pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt <= '0;
      wp      <= '0;
      rd      <= '0;
    end else begin
      if (state == CLR) clr_cnt <= clr_last ? '0 : clr_cnt + IW'(1);
      if (start) begin
        rd <= wp;
        wp <= (wp == IW'(KMAX-1)) ? '0 : wp + IW'(1);
      end
    end
  end

  // MAC issue counters, walking k inside c
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_cnt  <= '0;
      ch_cnt <= '0;
    end else if (start) begin
      k_cnt  <= '0;
      ch_cnt <= '0;
    end else if (state == MAC) begin
      if (k_cnt == IW'(KMAX-1)) begin
        k_cnt  <= '0;
        ch_cnt <= (ch_cnt == CW'(CH-1)) ? '0 : ch_cnt + CW'(1);
      end else begin
        k_cnt <= k_cnt + IW'(1);
      end
    end
  end

  // History memory has a single write port. CLR writes zeros, and an accepted
  // sample writes all channels at once. Reads are synchronous, so this block
  // also forms the RAM-read stage of the pipeline.
  always_ff @(posedge clk) begin
    if (state == CLR)  hist[clr_cnt] <= '0;
    else if (start)    hist[wp]      <= din;
    hist_q <= hist[raddr];
    coef_q <= coef[k_cnt];
  end

  // Coefficient port. Writes are dropped while busy and when out of range.
  always_ff @(posedge clk) begin
    if (cfg_we && cfg_rdy && ({1'b0, cfg_addr} < (AW+1)'(KMAX)))
      coef[cfg_addr[IW-1:0]] <= cfg_data;
  end

  // Pick the current channel's sample out of the wide history word
  always_comb begin
    smp_sel = '0;
    for (int c = 0; c < CH; c++)
      if (ch1 == CW'(c)) smp_sel = hist_q[c*WI +: WI];
  end

  // Pipeline valid tags. A restart kills everything in flight so the
  // products of an aborted pass never reach the freshly cleared accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      ch1  <= '0;
      ch2  <= '0;
      prod <= '0;
    end else begin
      v1   <= (state == MAC) && !start;
      ch1  <= ch_cnt;
      v2   <= v1 && !start;
      ch2  <= ch1;
      prod <= smp_sel * coef_q;
    end
  end

  // Per-channel accumulators, wide enough that KMAX products cannot wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) acc[c] <= '0;
    end else if (start) begin
      for (int c = 0; c < CH; c++) acc[c] <= '0;
    end else if (v2) begin
      for (int c = 0; c < CH; c++)
        if (ch2 == CW'(c)) acc[c] <= acc[c] + WA'(prod);
    end
  end

  function automatic logic [WI-1:0] sat(input logic signed [WA-1:0] a);
    logic signed [WA-1:0] s;
    s = a >>> SHIFT;
    if (s > MAXV)      s = MAXV;
    else if (s < MINV) s = MINV;
    return s[WI-1:0];
  endfunction

  // Output registers. OUT still completes when a sample lands in the same
  // cycle: dout and out_valid use the accumulators before they are cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout      <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= (state == OUT);
      overrun   <= sample && in_pass;
      if (state == OUT)
        for (int c = 0; c < CH; c++) dout[c*WI +: WI] <= sat(acc[c]);
    end
  end

endmodule

// File: tb/tb_jtframe_fir_mc.sv
// ---------------------------------------------------------------------------
// tb_jtframe_fir_mc
// Self-checking bench for jtframe_fir_mc with CH=3, KMAX=5, AW=3.
// KMAX is not a power of two, so the pointers must wrap modulo KMAX.
// The reference model keeps each channel's history as a plain array with the
// newest sample first. It computes every expected output as a direct
// convolution with integer arithmetic, followed by shift and clamp.
// ---------------------------------------------------------------------------
module tb_jtframe_fir_mc;

  localparam int WI    = 16;
  localparam int WC    = 16;
  localparam int CH    = 3;
  localparam int KMAX  = 5;
  localparam int AW    = 3;
  localparam int SHIFT = 14;
  localparam int DW    = CH*WI;
  localparam int LAT   = CH*KMAX + 4;

  logic          rst, clk, sample, cfg_we;
  logic [DW-1:0] din, dout;
  logic          out_valid, busy, overrun, cfg_rdy;
  logic [AW-1:0] cfg_addr;
  logic [WC-1:0] cfg_data;

  int vec_cnt = 0;
  int err_cnt = 0;

  int coef_m [KMAX];
  int hist_m [CH][KMAX];

  logic          val_h  [64];
  logic          ov_h   [64];
  logic [DW-1:0] dout_h [64];

  jtframe_fir_mc #(
    .WI(WI), .WC(WC), .CH(CH), .KMAX(KMAX), .AW(AW), .SHIFT(SHIFT), .COEFFS("")
  ) dut (
    .rst(rst), .clk(clk), .sample(sample), .din(din), .dout(dout),
    .out_valid(out_valid), .busy(busy), .overrun(overrun),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_rdy(cfg_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
    vec_cnt++;
    if (actual !== expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic void model_clear();
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < KMAX; k++) hist_m[c][k] = 0;
  endfunction

  function automatic void model_push(input logic [DW-1:0] d);
    logic signed [WI-1:0] s;
    for (int c = 0; c < CH; c++) begin
      for (int k = KMAX-1; k > 0; k--) hist_m[c][k] = hist_m[c][k-1];
      s = d[c*WI +: WI];
      hist_m[c][0] = int'(s);
    end
  endfunction

  function automatic logic [DW-1:0] model_out();
    logic [DW-1:0] res;
    longint acc;
    res = '0;
    for (int c = 0; c < CH; c++) begin
      acc = 0;
      for (int k = 0; k < KMAX; k++)
        acc += longint'(hist_m[c][k]) * longint'(coef_m[k]);
      acc = acc >>> SHIFT;
      if (acc > 32767)  acc = 32767;
      if (acc < -32768) acc = -32768;
      res[c*WI +: WI] = acc[WI-1:0];
    end
    return res;
  endfunction

  task automatic cfg_write(input int addr, input int data, input bit takes);
    logic signed [WC-1:0] v;
    v        = WC'(data);
    cfg_addr = AW'(addr);
    cfg_data = v;
    cfg_we   = 1'b1;
    tick();
    cfg_we   = 1'b0;
    if (takes && addr < KMAX) coef_m[addr] = int'(v);
  endtask

  // One sample, wait for its result, and check both latency and value
  task automatic apply_stimulus(input logic [DW-1:0] d, output logic [DW-1:0] got);
    logic [DW-1:0] exp;
    int  n;
    bit  seen;
    din    = d;
    sample = 1'b1;
    model_push(d);
    exp  = model_out();
    seen = 1'b0;
    tick();
    sample = 1'b0;
    n = 1;
    while (n < 60 && !seen) begin
      if (out_valid) seen = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    check_output("latency", seen ? n : -1, LAT);
    check_output("dout", dout, exp);
    got = dout;
  endtask

  // Two samples 'gap' cycles apart. Outputs are recorded per cycle, counted
  // from the first sample's cycle.
  task automatic run_pair(input int gap, output logic [DW-1:0] exp1,
                          output logic [DW-1:0] exp2);
    logic [DW-1:0] d1, d2;
    d1 = {16'($urandom), 16'($urandom), 16'($urandom)};
    d2 = {16'($urandom), 16'($urandom), 16'($urandom)};
    exp2 = '0;
    din = d1;
    sample = 1'b1;
    model_push(d1);
    exp1 = model_out();
    val_h[0] = out_valid; ov_h[0] = overrun; dout_h[0] = dout;
    for (int n = 1; n <= gap + 22; n++) begin
      tick();
      sample = 1'b0;
      if (n == gap) begin
        din = d2;
        sample = 1'b1;
        model_push(d2);
        exp2 = model_out();
      end
      val_h[n] = out_valid; ov_h[n] = overrun; dout_h[n] = dout;
    end
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    logic [DW-1:0] got, e1, e2;
    int n, nv, no;

    rst = 1'b1; sample = 1'b0; din = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    for (int k = 0; k < KMAX; k++) coef_m[k] = 0;
    model_clear();

    // Reset values
    tick(); tick(); tick();
    check_output("rst_dout", dout, 0);
    check_output("rst_valid", out_valid, 0);
    check_output("rst_overrun", overrun, 0);
    check_output("rst_busy", busy, 1);
    check_output("rst_cfg_rdy", cfg_rdy, 0);
    rst = 1'b0;
    count_busy(n);
    check_output("clr_cycles", n, KMAX);
    check_output("cfg_rdy_idle", cfg_rdy, 1);

    // Impulse: coef[k]=k+1, ch0 steps 1..KMAX then 0, other channels silent
    for (int k = 0; k < KMAX; k++) cfg_write(k, k + 1, 1'b1);
    cfg_write(KMAX, 999, 1'b0);
    apply_stimulus(48'h0000_0000_4000, got);
    check_output("impulse_0", got[15:0], 1);
    for (int i = 1; i <= KMAX + 1; i++) begin
      apply_stimulus('0, got);
      check_output("impulse_k", got[15:0], (i < KMAX) ? i + 1 : 0);
      check_output("isolation", got[47:16], 0);
    end

    // Random samples, with random coefficient rewrites between passes
    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(1) == 1)
        cfg_write($urandom_range(KMAX-1), int'($urandom_range(16'hFFFF)), 1'b1);
      if ($urandom_range(3) == 0)
        cfg_write($urandom_range(7, KMAX), int'($urandom_range(16'hFFFF)), 1'b0);
      apply_stimulus({16'($urandom), 16'($urandom), 16'($urandom)}, got);
      for (int j = 0; j < int'($urandom_range(5)); j++) tick();
    end

    // Overrun: second sample 5 cycles after the first
    run_pair(5, e1, e2);
    nv = 0; no = 0;
    for (int i = 1; i <= 27; i++) begin
      nv += int'(val_h[i]);
      no += int'(ov_h[i]);
    end
    check_output("ovr_pulse_at6", ov_h[6], 1);
    check_output("ovr_pulse_cnt", no, 1);
    check_output("ovr_no_valid_first", val_h[LAT], 0);
    check_output("ovr_dout_held", dout_h[LAT], dout_h[0]);
    check_output("ovr_valid_second", val_h[5 + LAT], 1);
    check_output("ovr_dout_second", dout_h[5 + LAT], e2);
    check_output("ovr_valid_cnt", nv, 1);

    // Sample arriving in the OUT cycle: both results are delivered
    run_pair(LAT - 1, e1, e2);
    nv = 0; no = 0;
    for (int i = 1; i <= 2*LAT + 2; i++) begin
      nv += int'(val_h[i]);
      no += int'(ov_h[i]);
    end
    check_output("out_valid_first", val_h[LAT], 1);
    check_output("out_dout_first", dout_h[LAT], e1);
    check_output("out_overrun", ov_h[LAT], 1);
    check_output("out_overrun_cnt", no, 1);
    check_output("out_valid_second", val_h[2*LAT - 1], 1);
    check_output("out_dout_second", dout_h[2*LAT - 1], e2);
    check_output("out_valid_cnt", nv, 2);

    // Saturation with every coefficient at 0x4000
    for (int k = 0; k < KMAX; k++) cfg_write(k, 16'h4000, 1'b1);
    for (int i = 0; i < KMAX; i++) apply_stimulus({3{16'h7FFF}}, got);
    check_output("sat_pos", got, {3{16'h7FFF}});
    for (int i = 0; i < KMAX; i++) apply_stimulus({3{16'h8000}}, got);
    check_output("sat_neg", got, {3{16'h8000}});

    // Reset in the middle of a pass
    din = {16'h1111, 16'h2222, 16'h3333};
    sample = 1'b1;
    tick();
    sample = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    check_output("midrst_dout", dout, 0);
    check_output("midrst_valid", out_valid, 0);
    check_output("midrst_busy", busy, 1);
    tick();
    rst = 1'b0;
    model_clear();
    cfg_addr = '0; cfg_data = 16'h1234; cfg_we = 1'b1;
    count_busy(n);
    cfg_we = 1'b0;
    check_output("midrst_clr_cycles", n, KMAX);
    apply_stimulus(48'h0000_0000_4000, got);
    check_output("coef_kept", got[15:0], 16'h4000);
    cfg_write(0, 7, 1'b1);
    apply_stimulus(48'h0000_0000_4000, got);
    check_output("coef_new", got[15:0], 16'h4007);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
